// File: rtl/gf180mcu_fd_sc_mcu9t5v0__capbank_seq.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu9t5v0__capbank_seq
//
// Purpose: sequences a bank of NSEG switchable decoupling-capacitor segments
// on and off one segment at a time. Segments are spaced DWELL clocks apart,
// which keeps the supply-current step small. SEG is a thermometer code:
// SEG[0] switches on first and off last.
//
// Parameters:
//   NSEG   number of segments (1..32)
//   DWELL  clocks between segment steps (1..255)
//
// Ports:
//   CLK        in   single clock; all state changes on its rising edge
//   RN         in   synchronous active-low reset; overrides every other input
//   EN         in   level request: 1 = bank fully on, 0 = bank fully off
//   HOLD       in   present only when GF180MCU_CAPBANK_HOLD_EN is defined;
//                   freezes a ramp in progress
//   SEG        out  thermometer segment enables (registered)
//   BUSY       out  high while ramping up or down (registered)
//   READY      out  high in ON with every segment enabled (registered)
//   DBG_STATE  out  current FSM state (OFF=0, RAMP_UP=1, ON=2, RAMP_DN=3)
//
// Interface note: EN is a level, not a handshake. The block follows it one
// segment at a time and reverses direction as soon as EN flips.
//
// Optional feature macro: GF180MCU_CAPBANK_HOLD_EN adds the HOLD input.
// With the macro undefined, the block behaves as if HOLD were tied to 0.
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu9t5v0__capbank_seq #(
  parameter int unsigned NSEG  = 8,
  parameter int unsigned DWELL = 4
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            EN,
`ifdef GF180MCU_CAPBANK_HOLD_EN
  input  logic            HOLD,
`endif
  output logic [NSEG-1:0] SEG,
  output logic            BUSY,
  output logic            READY,
  output logic [1:0]      DBG_STATE
);

  localparam int unsigned CW = $clog2(DWELL + 1);

  localparam logic [CW-1:0]   CNT_LAST = CW'(DWELL - 1);
  localparam logic [NSEG-1:0] SEG_FULL = '1;
  localparam logic [NSEG-1:0] SEG_ONE  = NSEG'(1);

  typedef enum logic [1:0] {
    ST_OFF     = 2'd0,
    ST_RAMP_UP = 2'd1,
    ST_ON      = 2'd2,
    ST_RAMP_DN = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [NSEG-1:0] seg_q, seg_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            hold_w;

  // One segment more or one segment fewer than now. Both results remain
  // valid thermometer codes.
  logic [NSEG-1:0] seg_up;
  logic [NSEG-1:0] seg_dn;

`ifdef GF180MCU_CAPBANK_HOLD_EN
  assign hold_w = HOLD;
`else
  assign hold_w = 1'b0;
`endif

  assign seg_up = (seg_q << 1) | SEG_ONE;
  assign seg_dn = seg_q >> 1;

  always_comb begin
    state_d = state_q;
    seg_d   = seg_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_OFF: begin
        cnt_d = '0;
        seg_d = '0;
        if (EN) begin
          seg_d   = SEG_ONE;
          state_d = (NSEG == 1) ? ST_ON : ST_RAMP_UP;
        end
      end

      ST_RAMP_UP: begin
        // HOLD only freezes a ramp. Any EN reversal is picked up once HOLD drops.
        if (!hold_w) begin
          if (EN) begin
            if (cnt_q == CNT_LAST) begin
              seg_d = seg_up;
              cnt_d = '0;
              if (seg_up == SEG_FULL) state_d = ST_ON;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Reverse at once by dropping the top segment.
            seg_d   = seg_dn;
            cnt_d   = '0;
            state_d = (seg_dn == '0) ? ST_OFF : ST_RAMP_DN;
          end
        end
      end

      ST_ON: begin
        cnt_d = '0;
        if (!EN) begin
          seg_d   = seg_dn;
          state_d = (seg_dn == '0) ? ST_OFF : ST_RAMP_DN;
        end
      end

      ST_RAMP_DN: begin
        if (!hold_w) begin
          if (!EN) begin
            if (cnt_q == CNT_LAST) begin
              seg_d = seg_dn;
              cnt_d = '0;
              if (seg_dn == '0) state_d = ST_OFF;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            // Reverse at once by adding the next segment.
            seg_d   = seg_up;
            cnt_d   = '0;
            state_d = (seg_up == SEG_FULL) ? ST_ON : ST_RAMP_UP;
          end
        end
      end

      default: begin
        state_d = ST_OFF;
        seg_d   = '0;
        cnt_d   = '0;
      end
    endcase

    // BUSY and READY are derived from the next state, so each registered
    // flag changes on the same edge as SEG.
    busy_d  = (state_d == ST_RAMP_UP) || (state_d == ST_RAMP_DN);
    ready_d = (state_d == ST_ON) && (seg_d == SEG_FULL);
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      state_q <= ST_OFF;
      seg_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      seg_q   <= seg_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      ready_q <= ready_d;
    end
  end

  assign SEG       = seg_q;
  assign BUSY      = busy_q;
  assign READY     = ready_q;
  assign DBG_STATE = state_q;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__capbank_seq.sv
// -----------------------------------------------------------------------------
// tb_gf180mcu_fd_sc_mcu9t5v0__capbank_seq
//
// Directed bench for the capacitor-bank sequencer. dut uses the default
// parameters (NSEG=8, DWELL=4). dut1 uses NSEG=1, DWELL=1. Inputs change
// 1 ns after a rising edge. Outputs are sampled at that same point, so they
// show the result of the edge that just occurred.
// -----------------------------------------------------------------------------
module tb_gf180mcu_fd_sc_mcu9t5v0__capbank_seq;

  localparam logic [1:0] S_OFF = 2'd0;
  localparam logic [1:0] S_UP  = 2'd1;
  localparam logic [1:0] S_ON  = 2'd2;
  localparam logic [1:0] S_DN  = 2'd3;

  logic       clk;
  logic       rn, en, hold;
  logic [7:0] seg;
  logic       busy, ready;
  logic [1:0] st;

  logic       rn1, en1, hold1;
  logic [0:0] seg1;
  logic       busy1, ready1;
  logic [1:0] st1;

  int n_pass;
  int n_total;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  gf180mcu_fd_sc_mcu9t5v0__capbank_seq #(.NSEG(8), .DWELL(4)) dut (
    .CLK(clk), .RN(rn), .EN(en),
`ifdef GF180MCU_CAPBANK_HOLD_EN
    .HOLD(hold),
`endif
    .SEG(seg), .BUSY(busy), .READY(ready), .DBG_STATE(st)
  );

  gf180mcu_fd_sc_mcu9t5v0__capbank_seq #(.NSEG(1), .DWELL(1)) dut1 (
    .CLK(clk), .RN(rn1), .EN(en1),
`ifdef GF180MCU_CAPBANK_HOLD_EN
    .HOLD(hold1),
`endif
    .SEG(seg1), .BUSY(busy1), .READY(ready1), .DBG_STATE(st1)
  );

  // Advance one rising edge. Returns 1 ns after it.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rn = 1'b0; en = 1'b1; hold = 1'b0;
    rn1 = 1'b0; en1 = 1'b1; hold1 = 1'b0;
    step(3);
    n_total++;
    if (seg !== 8'h00) $display("FAIL reset_seg: got %h want 00", seg); else n_pass++;
    n_total++;
    if (busy !== 1'b0 || ready !== 1'b0)
      $display("FAIL reset_flags: busy=%b ready=%b want 0 0", busy, ready);
    else n_pass++;
    n_total++;
    if (st !== S_OFF) $display("FAIL reset_state: got %0d want %0d", st, S_OFF); else n_pass++;
    n_total++;
    if (seg1 !== 1'b0 || ready1 !== 1'b0)
      $display("FAIL reset_dut1: seg=%b ready=%b want 0 0", seg1, ready1);
    else n_pass++;
    en = 1'b0; en1 = 1'b0;
    step(1);
    rn = 1'b1; rn1 = 1'b1;
    step(2);
    n_total++;
    if (seg !== 8'h00 || st !== S_OFF)
      $display("FAIL off_idle: seg=%h st=%0d want 00 %0d", seg, st, S_OFF);
    else n_pass++;
  endtask

  task automatic test_ramp_up();
    en = 1'b1;
    for (int e = 1; e <= 29; e++) begin
      step(1);
      if (e == 1) begin
        n_total++;
        if (seg !== 8'h01 || busy !== 1'b1 || st !== S_UP)
          $display("FAIL up_e1: seg=%h busy=%b st=%0d want 01 1 %0d", seg, busy, st, S_UP);
        else n_pass++;
      end
      if (e == 4) begin
        n_total++;
        if (seg !== 8'h01) $display("FAIL up_e4: got %h want 01", seg); else n_pass++;
      end
      if (e == 5) begin
        n_total++;
        if (seg !== 8'h03) $display("FAIL up_e5: got %h want 03", seg); else n_pass++;
      end
      if (e == 28) begin
        n_total++;
        if (seg !== 8'h7F || ready !== 1'b0 || busy !== 1'b1)
          $display("FAIL up_e28: seg=%h ready=%b busy=%b want 7f 0 1", seg, ready, busy);
        else n_pass++;
      end
      if (e == 29) begin
        n_total++;
        if (seg !== 8'hFF || ready !== 1'b1 || busy !== 1'b0 || st !== S_ON)
          $display("FAIL up_e29: seg=%h ready=%b busy=%b st=%0d want ff 1 0 %0d",
                   seg, ready, busy, st, S_ON);
        else n_pass++;
      end
    end
    step(6);
    n_total++;
    if (seg !== 8'hFF || ready !== 1'b1 || st !== S_ON)
      $display("FAIL on_hold: seg=%h ready=%b st=%0d want ff 1 %0d", seg, ready, st, S_ON);
    else n_pass++;
  endtask

  task automatic test_ramp_down();
    en = 1'b0;
    for (int e = 1; e <= 29; e++) begin
      step(1);
      if (e == 1) begin
        n_total++;
        if (seg !== 8'h7F || busy !== 1'b1 || ready !== 1'b0 || st !== S_DN)
          $display("FAIL dn_e1: seg=%h busy=%b ready=%b st=%0d want 7f 1 0 %0d",
                   seg, busy, ready, st, S_DN);
        else n_pass++;
      end
      if (e == 5) begin
        n_total++;
        if (seg !== 8'h3F) $display("FAIL dn_e5: got %h want 3f", seg); else n_pass++;
      end
      if (e == 28) begin
        n_total++;
        if (seg !== 8'h01) $display("FAIL dn_e28: got %h want 01", seg); else n_pass++;
      end
      if (e == 29) begin
        n_total++;
        if (seg !== 8'h00 || busy !== 1'b0 || st !== S_OFF)
          $display("FAIL dn_e29: seg=%h busy=%b st=%0d want 00 0 %0d", seg, busy, st, S_OFF);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reversal();
    en = 1'b1;
    step(9);
    n_total++;
    if (seg !== 8'h07) $display("FAIL rev_up9: got %h want 07", seg); else n_pass++;
    en = 1'b0;
    step(1);
    n_total++;
    if (seg !== 8'h03 || st !== S_DN)
      $display("FAIL rev_first: seg=%h st=%0d want 03 %0d", seg, st, S_DN);
    else n_pass++;
    step(3);
    n_total++;
    if (seg !== 8'h03) $display("FAIL rev_dwell: got %h want 03", seg); else n_pass++;
    step(1);
    n_total++;
    if (seg !== 8'h01) $display("FAIL rev_01: got %h want 01", seg); else n_pass++;
    step(4);
    n_total++;
    if (seg !== 8'h00 || st !== S_OFF || busy !== 1'b0)
      $display("FAIL rev_00: seg=%h st=%0d busy=%b want 00 %0d 0", seg, st, busy, S_OFF);
    else n_pass++;
  endtask

  task automatic test_dn_to_up();
    en = 1'b1;
    step(9);
    en = 1'b0;
    step(1);
    en = 1'b1;
    step(1);
    n_total++;
    if (seg !== 8'h07 || st !== S_UP || busy !== 1'b1)
      $display("FAIL d2u_first: seg=%h st=%0d busy=%b want 07 %0d 1", seg, st, busy, S_UP);
    else n_pass++;
    step(3);
    n_total++;
    if (seg !== 8'h07) $display("FAIL d2u_dwell: got %h want 07", seg); else n_pass++;
    step(1);
    n_total++;
    if (seg !== 8'h0F) $display("FAIL d2u_step: got %h want 0f", seg); else n_pass++;
    // Return to OFF, with a bounded wait.
    en = 1'b0;
    for (int i = 0; i < 100 && seg !== 8'h00; i++) step(1);
    n_total++;
    if (seg !== 8'h00 || st !== S_OFF)
      $display("FAIL d2u_drain: seg=%h st=%0d want 00 %0d", seg, st, S_OFF);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    en = 1'b1;
    step(17);
    n_total++;
    if (seg !== 8'h1F || st !== S_UP)
      $display("FAIL rst_pre: seg=%h st=%0d want 1f %0d", seg, st, S_UP);
    else n_pass++;
    rn = 1'b0;
    step(1);
    n_total++;
    if (seg !== 8'h00 || busy !== 1'b0 || ready !== 1'b0 || st !== S_OFF)
      $display("FAIL rst_mid: seg=%h busy=%b ready=%b st=%0d want 00 0 0 %0d",
               seg, busy, ready, st, S_OFF);
    else n_pass++;
    rn = 1'b1;
    step(1);
    n_total++;
    if (seg !== 8'h01 || st !== S_UP)
      $display("FAIL rst_release: seg=%h st=%0d want 01 %0d", seg, st, S_UP);
    else n_pass++;
    rn = 1'b0; en = 1'b0;
    step(1);
    rn = 1'b1;
    step(1);
  endtask

  task automatic test_nseg1();
    en1 = 1'b1;
    step(1);
    n_total++;
    if (seg1 !== 1'b1 || ready1 !== 1'b1 || busy1 !== 1'b0 || st1 !== S_ON)
      $display("FAIL n1_on: seg=%b ready=%b busy=%b st=%0d want 1 1 0 %0d",
               seg1, ready1, busy1, st1, S_ON);
    else n_pass++;
    en1 = 1'b0;
    step(1);
    n_total++;
    if (seg1 !== 1'b0 || ready1 !== 1'b0 || busy1 !== 1'b0 || st1 !== S_OFF)
      $display("FAIL n1_off: seg=%b ready=%b busy=%b st=%0d want 0 0 0 %0d",
               seg1, ready1, busy1, st1, S_OFF);
    else n_pass++;
  endtask

`ifdef GF180MCU_CAPBANK_HOLD_EN
  task automatic test_hold();
    int bad;
    en = 1'b1;
    step(7);
    n_total++;
    if (seg !== 8'h03) $display("FAIL hold_pre: got %h want 03", seg); else n_pass++;
    hold = 1'b1;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (seg !== 8'h03 || st !== S_UP) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL hold_freeze: %0d bad edges want 0 (seg=%h)", bad, seg);
    else n_pass++;
    hold = 1'b0;
    step(1);
    n_total++;
    if (seg !== 8'h03) $display("FAIL hold_rel1: got %h want 03", seg); else n_pass++;
    step(1);
    n_total++;
    if (seg !== 8'h07) $display("FAIL hold_rel2: got %h want 07", seg); else n_pass++;
    rn = 1'b0; en = 1'b0;
    step(1);
    rn = 1'b1;
    step(1);
  endtask
`endif

  initial begin
    n_pass  = 0;
    n_total = 0;
    test_reset();
    test_ramp_up();
    test_ramp_down();
    test_reversal();
    test_dn_to_up();
    test_reset_mid();
    test_nseg1();
`ifdef GF180MCU_CAPBANK_HOLD_EN
    test_hold();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
